instruction_decode: RTL and testbench
=====================================

// Module: instruction_decode
// PURPOSE
//  Decode stage directly downstream of instruction fetch. Holds the IF/ID register (instr, pcNext),
//  decodes 16-bit opcode[15:12] into control + register addresses, detects load-use hazards and
//  drives stall/hlt back to fetch. Registers the decoded bundle into ID/EX for execute.
//  Register-file read is external; rf_addr1/rf_addr2 are combinational from the IF/ID instruction.
// PARAMETERS
//  NOP_INSTR  16'h0000  instruction value loaded into IF/ID on flush/reset (ADD R0,R0,R0)
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   asynchronous, active-low reset
//  instr        in   16  instruction from fetch
//  pcNext       in   16  fetch pcNext (PC+1 of instr)
//  flush        in   1   branch/jump taken in EX; kill IF/ID and ID/EX-incoming
//  stall        out  1   to fetch: hold PC (load-use hazard)
//  hlt          out  1   to fetch: freeze PC; sticky until reset
//  rf_addr1     out  4   read address 1 (src1)
//  rf_addr2     out  4   read address 2 (src2)
//  idex_valid   out  1   ID/EX holds a real instruction
//  idex_opcode  out  4   opcode (ALU op select for execute)
//  idex_dst     out  4   destination register
//  idex_src1    out  4   src1 address (forwarding compare)
//  idex_src2    out  4   src2 address (forwarding compare)
//  idex_imm     out  16  extended immediate
//  idex_pc      out  16  pcNext of the instruction
//  idex_cond    out  3   branch condition instr[11:9]
//  idex_regWrite/idex_memRead/idex_memWrite/idex_branch/idex_jal/idex_jr/idex_hlt  out 1 each
// BEHAVIOUR
//  Opcodes: 0-7 ADD,ADDZ,SUB,AND,NOR,SLL,SRL,SRA; 8 LW; 9 SW; A LHB; B LLB; C B; D JAL; E JR; F HLT.
//  Sources: ALU 0-4 src1=[7:4] src2=[3:0]; shifts src1=[7:4] only; LW src1=[7:4]; SW src1=[7:4]
//   src2=[11:8]; LHB src1=[11:8]; JR src1=[7:4]; LLB,B,JAL,HLT none. Unused source addr = 0.
//  dst: [11:8] for 0-8,A,B; 15 for JAL; else 0. regWrite = writer opcode AND dst!=0.
//  imm: shifts {12'b0,[3:0]}; LW/SW sext[3:0]; LHB {8'b0,[7:0]}; LLB sext[7:0]; B sext[8:0];
//   JAL sext[11:0]; else 0.
//  IF/ID reg (ifid_valid, ifid_instr, ifid_pc), priority per posedge: flush -> valid=0,
//   instr=NOP_INSTR; else stall or hlt -> hold; else capture instr/pcNext, valid=1.
//  load_use = idex_valid & idex_memRead & ifid_valid & idex_dst!=0 & idex_dst matches a used src.
//  stall = load_use & ~flush & ~hlt (combinational). R0 matches never stall.
//  ID/EX reg: flush or load_use or ~ifid_valid or hlt already set -> bubble (valid=0, all control
//   0, addresses/imm/pc 0); else load decoded bundle, valid=1. Latency IF/ID -> ID/EX: 1 cycle.
//  Stall lasts exactly one cycle per LW (bubble clears the hazard on the next compare).
//  hlt: set on posedge when decoded HLT enters ID/EX (valid, no flush); sticky; IF/ID frozen,
//   ID/EX receives only bubbles thereafter. Flush same cycle as HLT decode -> HLT killed, hlt=0.
//  Reset (async): ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0, all idex_* =0, hlt=0, stall=0.
//  Reset mid-stall/mid-halt: everything cleared immediately, fetch resumes at PC 0 next cycle.
// TESTING
//  1 rst_n=0 with random instr -> all idex_* 0, stall=0, hlt=0; release -> first instr valid 2 cycles.
//  2 instr=16'h0123 pcNext=16'h0005 -> next cycle idex_valid=1 dst=1 src1=2 src2=3 regWrite=1 pc=5.
//  3 LW 16'h8421 then ADD 16'h0546 -> stall=1 one cycle, ID/EX bubble, then ADD issues valid=1.
//  4 LW 16'h8421 then LLB 16'hB4FF -> no stall; LLB imm=16'hFFFF dst=4; LW to R0 + use R0 -> no stall.
//  5 load-use hazard with flush=1 same cycle -> stall=0, ID/EX bubble, IF/ID valid=0 next cycle.
//  6 instr=16'hF000 -> idex_hlt=1, hlt=1 sticky; later instrs ignored, bubbles; rst_n=0 clears hlt.

Source files
------------

// File: rtl/instruction_decode.sv
// instruction_decode
//   Decode stage sitting directly after fetch. It holds the IF/ID register,
//   decodes the 16-bit instruction (opcode in [15:12]) into control and register
//   addresses, detects load-use hazards and registers the decoded bundle into
//   ID/EX for execute.
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   instr, pcNext                   instruction and its PC+1 from fetch
//   flush                           taken branch/jump in EX: kill IF/ID and the incoming ID/EX
//   stall                           to fetch: hold PC for one load-use bubble
//   hlt                             to fetch: freeze PC, sticky until reset
//   rf_addr1, rf_addr2              combinational register-file read addresses
//   idex_*                          registered decoded bundle for execute
module instruction_decode #(
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic [15:0] pcNext,
    input  logic        flush,
    output logic        stall,
    output logic        hlt,
    output logic [3:0]  rf_addr1,
    output logic [3:0]  rf_addr2,
    output logic        idex_valid,
    output logic [3:0]  idex_opcode,
    output logic [3:0]  idex_dst,
    output logic [3:0]  idex_src1,
    output logic [3:0]  idex_src2,
    output logic [15:0] idex_imm,
    output logic [15:0] idex_pc,
    output logic [2:0]  idex_cond,
    output logic        idex_regWrite,
    output logic        idex_memRead,
    output logic        idex_memWrite,
    output logic        idex_branch,
    output logic        idex_jal,
    output logic        idex_jr,
    output logic        idex_hlt
);

    logic        ifid_valid_r;
    logic [15:0] ifid_instr_r;
    logic [15:0] ifid_pc_r;

    logic [3:0]  opcode_s;
    logic [3:0]  dst_s;
    logic [3:0]  src1_s;
    logic [3:0]  src2_s;
    logic [15:0] imm_s;
    logic [2:0]  cond_s;
    logic        writer_s;
    logic        reg_write_s;
    logic        mem_read_s;
    logic        mem_write_s;
    logic        branch_s;
    logic        jal_s;
    logic        jr_s;
    logic        halt_s;
    logic        load_use_s;
    logic        idex_load_s;

    // Decode the IF/ID instruction; unused source addresses stay 0 so they never match a load dst.
    always_comb begin
        opcode_s    = ifid_instr_r[15:12];
        dst_s       = 4'd0;
        src1_s      = 4'd0;
        src2_s      = 4'd0;
        imm_s       = 16'h0000;
        cond_s      = 3'd0;
        writer_s    = 1'b0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        branch_s    = 1'b0;
        jal_s       = 1'b0;
        jr_s        = 1'b0;
        halt_s      = 1'b0;
        case (opcode_s)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin
                src1_s   = ifid_instr_r[7:4];
                src2_s   = ifid_instr_r[3:0];
                dst_s    = ifid_instr_r[11:8];
                writer_s = 1'b1;
            end
            4'h5, 4'h6, 4'h7: begin
                src1_s   = ifid_instr_r[7:4];
                dst_s    = ifid_instr_r[11:8];
                imm_s    = {12'h000, ifid_instr_r[3:0]};
                writer_s = 1'b1;
            end
            4'h8: begin
                src1_s     = ifid_instr_r[7:4];
                dst_s      = ifid_instr_r[11:8];
                imm_s      = {{12{ifid_instr_r[3]}}, ifid_instr_r[3:0]};
                writer_s   = 1'b1;
                mem_read_s = 1'b1;
            end
            4'h9: begin
                src1_s      = ifid_instr_r[7:4];
                src2_s      = ifid_instr_r[11:8];
                imm_s       = {{12{ifid_instr_r[3]}}, ifid_instr_r[3:0]};
                mem_write_s = 1'b1;
            end
            4'hA: begin
                src1_s   = ifid_instr_r[11:8];
                dst_s    = ifid_instr_r[11:8];
                imm_s    = {8'h00, ifid_instr_r[7:0]};
                writer_s = 1'b1;
            end
            4'hB: begin
                dst_s    = ifid_instr_r[11:8];
                imm_s    = {{8{ifid_instr_r[7]}}, ifid_instr_r[7:0]};
                writer_s = 1'b1;
            end
            4'hC: begin
                imm_s    = {{7{ifid_instr_r[8]}}, ifid_instr_r[8:0]};
                cond_s   = ifid_instr_r[11:9];
                branch_s = 1'b1;
            end
            4'hD: begin
                dst_s    = 4'd15;
                imm_s    = {{4{ifid_instr_r[11]}}, ifid_instr_r[11:0]};
                writer_s = 1'b1;
                jal_s    = 1'b1;
            end
            4'hE: begin
                src1_s = ifid_instr_r[7:4];
                jr_s   = 1'b1;
            end
            4'hF: begin
                halt_s = 1'b1;
            end
            default: begin
                halt_s = 1'b0;
            end
        endcase
        reg_write_s = writer_s & (dst_s != 4'd0);
    end

    // Load in ID/EX whose destination feeds an operand of the instruction in IF/ID.
    always_comb begin
        load_use_s  = idex_valid & idex_memRead & ifid_valid_r & (idex_dst != 4'd0)
                    & ((idex_dst == src1_s) | (idex_dst == src2_s));
        idex_load_s = ~flush & ~load_use_s & ifid_valid_r & ~hlt;
        stall       = load_use_s & ~flush & ~hlt;
        rf_addr1    = src1_s;
        rf_addr2    = src2_s;
    end

    // IF/ID register: flush kills, stall or halt holds, otherwise capture from fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_valid_r <= 1'b0;
            ifid_instr_r <= NOP_INSTR;
            ifid_pc_r    <= 16'h0000;
        end else if (flush) begin
            ifid_valid_r <= 1'b0;
            ifid_instr_r <= NOP_INSTR;
            ifid_pc_r    <= 16'h0000;
        end else if (stall || hlt) begin
            ifid_valid_r <= ifid_valid_r;
            ifid_instr_r <= ifid_instr_r;
            ifid_pc_r    <= ifid_pc_r;
        end else begin
            ifid_valid_r <= 1'b1;
            ifid_instr_r <= instr;
            ifid_pc_r    <= pcNext;
        end
    end

    // ID/EX register: decoded bundle or an all-zero bubble; HLT entering sets sticky hlt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_valid    <= 1'b0;
            idex_opcode   <= 4'd0;
            idex_dst      <= 4'd0;
            idex_src1     <= 4'd0;
            idex_src2     <= 4'd0;
            idex_imm      <= 16'h0000;
            idex_pc       <= 16'h0000;
            idex_cond     <= 3'd0;
            idex_regWrite <= 1'b0;
            idex_memRead  <= 1'b0;
            idex_memWrite <= 1'b0;
            idex_branch   <= 1'b0;
            idex_jal      <= 1'b0;
            idex_jr       <= 1'b0;
            idex_hlt      <= 1'b0;
            hlt           <= 1'b0;
        end else begin
            idex_valid    <= idex_load_s;
            idex_opcode   <= idex_load_s ? opcode_s  : 4'd0;
            idex_dst      <= idex_load_s ? dst_s     : 4'd0;
            idex_src1     <= idex_load_s ? src1_s    : 4'd0;
            idex_src2     <= idex_load_s ? src2_s    : 4'd0;
            idex_imm      <= idex_load_s ? imm_s     : 16'h0000;
            idex_pc       <= idex_load_s ? ifid_pc_r : 16'h0000;
            idex_cond     <= idex_load_s ? cond_s    : 3'd0;
            idex_regWrite <= idex_load_s & reg_write_s;
            idex_memRead  <= idex_load_s & mem_read_s;
            idex_memWrite <= idex_load_s & mem_write_s;
            idex_branch   <= idex_load_s & branch_s;
            idex_jal      <= idex_load_s & jal_s;
            idex_jr       <= idex_load_s & jr_s;
            idex_hlt      <= idex_load_s & halt_s;
            hlt           <= hlt | (idex_load_s & halt_s);
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// tb_instruction_decode
//   Directed scenarios plus randomized instruction streams against a behavioural
//   pipeline model of the decode stage.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic [15:0] pcNext;
    logic        flush;
    logic        stall;
    logic        hlt;
    logic [3:0]  rf_addr1;
    logic [3:0]  rf_addr2;
    logic        idex_valid;
    logic [3:0]  idex_opcode;
    logic [3:0]  idex_dst;
    logic [3:0]  idex_src1;
    logic [3:0]  idex_src2;
    logic [15:0] idex_imm;
    logic [15:0] idex_pc;
    logic [2:0]  idex_cond;
    logic        idex_regWrite;
    logic        idex_memRead;
    logic        idex_memWrite;
    logic        idex_branch;
    logic        idex_jal;
    logic        idex_jr;
    logic        idex_hlt;

    int n_vec = 0;
    int n_bad = 0;

    instruction_decode dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .pcNext(pcNext), .flush(flush),
        .stall(stall), .hlt(hlt), .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
        .idex_valid(idex_valid), .idex_opcode(idex_opcode), .idex_dst(idex_dst),
        .idex_src1(idex_src1), .idex_src2(idex_src2), .idex_imm(idex_imm),
        .idex_pc(idex_pc), .idex_cond(idex_cond), .idex_regWrite(idex_regWrite),
        .idex_memRead(idex_memRead), .idex_memWrite(idex_memWrite),
        .idex_branch(idex_branch), .idex_jal(idex_jal), .idex_jr(idex_jr),
        .idex_hlt(idex_hlt)
    );

    // free-running clock
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [3:0]  op, dst, s1, s2;
        logic [15:0] imm, pc;
        logic [2:0]  cond;
        logic        rw, mr, mw, br, jal, jr, hl;
    } bnd_t;

    // reference state
    logic        m_fv;
    logic [15:0] m_fi, m_fp;
    bnd_t        m_x;
    logic        m_hlt;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // low n bits of w as a signed integer
    function automatic int sx(input logic [15:0] w, input int n);
        int v;
        v = int'(w) & ((1 << n) - 1);
        if (v >= (1 << (n - 1))) v = v - (1 << n);
        return v;
    endfunction

    function automatic bnd_t ref_decode(input logic [15:0] w, input logic [15:0] pc);
        bnd_t b;
        int   op;
        int   v;
        b  = '0;
        op = int'(w[15:12]);
        b.v  = 1'b1;
        b.op = w[15:12];
        b.pc = pc;
        if (op <= 9 || op == 14) b.s1 = w[7:4];
        else if (op == 10)       b.s1 = w[11:8];
        if (op <= 4)       b.s2 = w[3:0];
        else if (op == 9)  b.s2 = w[11:8];
        if (op <= 8 || op == 10 || op == 11) b.dst = w[11:8];
        else if (op == 13)                   b.dst = 4'd15;
        b.rw  = (op <= 8 || op == 10 || op == 11 || op == 13) && (b.dst != 4'd0);
        b.mr  = (op == 8);
        b.mw  = (op == 9);
        b.br  = (op == 12);
        b.jal = (op == 13);
        b.jr  = (op == 14);
        b.hl  = (op == 15);
        if (op == 12) b.cond = w[11:9];
        case (op)
            5, 6, 7: v = int'(w[3:0]);
            8, 9:    v = sx(w, 4);
            10:      v = int'(w[7:0]);
            11:      v = sx(w, 8);
            12:      v = sx(w, 9);
            13:      v = sx(w, 12);
            default: v = 0;
        endcase
        b.imm = v[15:0];
        return b;
    endfunction

    task automatic check_idex();
        chk("idex_valid", {15'd0, idex_valid}, {15'd0, m_x.v});
        chk("idex_opcode", {12'd0, idex_opcode}, {12'd0, m_x.op});
        chk("idex_dst", {12'd0, idex_dst}, {12'd0, m_x.dst});
        chk("idex_src1", {12'd0, idex_src1}, {12'd0, m_x.s1});
        chk("idex_src2", {12'd0, idex_src2}, {12'd0, m_x.s2});
        chk("idex_imm", idex_imm, m_x.imm);
        chk("idex_pc", idex_pc, m_x.pc);
        chk("idex_cond", {13'd0, idex_cond}, {13'd0, m_x.cond});
        chk("idex_ctrl", {9'd0, idex_regWrite, idex_memRead, idex_memWrite, idex_branch,
                          idex_jal, idex_jr, idex_hlt},
                         {9'd0, m_x.rw, m_x.mr, m_x.mw, m_x.br, m_x.jal, m_x.jr, m_x.hl});
        chk("hlt", {15'd0, hlt}, {15'd0, m_hlt});
    endtask

    // one clock: drive at negedge, check comb outputs, advance model at posedge, check ID/EX
    task automatic step(input logic [15:0] i, input logic [15:0] p, input logic f);
        bnd_t d;
        bnd_t nx;
        logic lu;
        logic st;
        @(negedge clk);
        instr = i; pcNext = p; flush = f;
        #1;
        d  = ref_decode(m_fi, m_fp);
        lu = m_x.v && m_x.mr && m_fv && (m_x.dst != 4'd0) && (m_x.dst == d.s1 || m_x.dst == d.s2);
        st = lu && !f && !m_hlt;
        chk("stall", {15'd0, stall}, {15'd0, st});
        chk("rf_addr1", {12'd0, rf_addr1}, {12'd0, d.s1});
        chk("rf_addr2", {12'd0, rf_addr2}, {12'd0, d.s2});
        nx = (f || lu || !m_fv || m_hlt) ? bnd_t'('0) : d;
        @(posedge clk);
        #1;
        if (f) begin
            m_fv = 1'b0; m_fi = 16'h0000; m_fp = 16'h0000;
        end else if (!(st || m_hlt)) begin
            m_fv = 1'b1; m_fi = i; m_fp = p;
        end
        if (nx.v && nx.hl) m_hlt = 1'b1;
        m_x = nx;
        check_idex();
    endtask

    // asynchronous reset applied mid-cycle, checked immediately
    task automatic do_reset();
        @(negedge clk);
        instr = 16'($urandom); pcNext = 16'($urandom); flush = 1'b0;
        rst_n = 1'b0;
        #1;
        m_fv = 1'b0; m_fi = 16'h0000; m_fp = 16'h0000; m_x = '0; m_hlt = 1'b0;
        check_idex();
        chk("rst_stall", {15'd0, stall}, 16'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] w;
        rst_n = 1'b0; instr = 16'h0000; pcNext = 16'h0000; flush = 1'b0;
        m_fv = 1'b0; m_fi = 16'h0000; m_fp = 16'h0000; m_x = '0; m_hlt = 1'b0;
        do_reset();

        // basic ALU issue, two cycles after reset release
        step(16'h0123, 16'h0005, 1'b0);
        chk("t2_lat_valid", {15'd0, idex_valid}, 16'd0);
        step(16'h0000, 16'h0006, 1'b0);
        chk("t2_valid", {15'd0, idex_valid}, 16'd1);
        chk("t2_dst", {12'd0, idex_dst}, 16'd1);
        chk("t2_src", {8'd0, idex_src1, idex_src2}, 16'h0023);
        chk("t2_rw", {15'd0, idex_regWrite}, 16'd1);
        chk("t2_pc", idex_pc, 16'h0005);

        // LW then dependent ADD: one stall cycle, one bubble
        step(16'h8421, 16'h0010, 1'b0);
        step(16'h0546, 16'h0011, 1'b0);
        chk("t3_stall", {15'd0, stall}, 16'd1);
        step(16'h0546, 16'h0011, 1'b0);
        chk("t3_bubble", {15'd0, idex_valid}, 16'd0);
        chk("t3_stall_clr", {15'd0, stall}, 16'd0);
        step(16'h0000, 16'h0012, 1'b0);
        chk("t3_add_valid", {15'd0, idex_valid}, 16'd1);
        chk("t3_add_dst", {12'd0, idex_dst}, 16'd5);

        // LW then independent LLB; LW to R0 followed by R0 use
        step(16'h8421, 16'h0020, 1'b0);
        step(16'hB4FF, 16'h0021, 1'b0);
        chk("t4_nostall", {15'd0, stall}, 16'd0);
        step(16'h8021, 16'h0022, 1'b0);
        chk("t4_llb_imm", idex_imm, 16'hFFFF);
        chk("t4_llb_dst", {12'd0, idex_dst}, 16'd4);
        step(16'h0100, 16'h0023, 1'b0);
        chk("t4_r0_nostall", {15'd0, stall}, 16'd0);

        // load-use hazard coinciding with flush
        step(16'h8421, 16'h0030, 1'b0);
        step(16'h0546, 16'h0031, 1'b0);
        step(16'h0546, 16'h0031, 1'b1);
        chk("t5_bubble", {15'd0, idex_valid}, 16'd0);
        step(16'h0000, 16'h0040, 1'b0);
        chk("t5_ifid_killed", {15'd0, idex_valid}, 16'd0);

        // HLT: sticky, only bubbles afterwards, cleared by reset
        step(16'hF000, 16'h0050, 1'b0);
        step(16'h0123, 16'h0051, 1'b0);
        chk("t6_idex_hlt", {15'd0, idex_hlt}, 16'd1);
        chk("t6_hlt", {15'd0, hlt}, 16'd1);
        step(16'h0123, 16'h0052, 1'b0);
        step(16'h0456, 16'h0053, 1'b0);
        chk("t6_bubble", {15'd0, idex_valid}, 16'd0);
        chk("t6_sticky", {15'd0, hlt}, 16'd1);
        do_reset();
        chk("t6_rst_hlt", {15'd0, hlt}, 16'd0);

        // randomized streams, small register range to provoke hazards
        for (int n = 0; n < 500; n++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 1) == 0) w = w & 16'hF333;
            if ($urandom_range(0, 3) == 0) w[15:12] = 4'h8;
            if (w[15:12] == 4'hF && $urandom_range(0, 1) == 0) w[15:12] = 4'h0;
            step(w, 16'($urandom), ($urandom_range(0, 9) == 0));
            if ((m_hlt && $urandom_range(0, 3) == 0) || $urandom_range(0, 59) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
